req_arbiter_4: RTL and testbench
================================

Name: req_arbiter_4

Overview:
- Four-requester bus/resource arbiter built around a 4:2 priority-encode function: req[3] has highest fixed priority, req[0] lowest.
- Sequences ownership of a single shared resource: registered one-hot grant, grant hold while the owner keeps requesting, forced release after MAX_HOLD cycles, and one-cycle dead time between owners.
- Sits between the four client request lines and the shared datapath mux select.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant (legal range 2..2**CNT_W).
- CNT_W, 4: width of the hold counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; req[k]=1 means requester k wants the resource.
- gnt  output  4  one-hot grant, registered; all-zero when nobody owns the resource.
- gnt_id  output  2  encoded index of the current owner; valid only while gnt_valid=1.
- gnt_valid  output  1  high exactly when gnt != 0.
- timeout  output  1  one-cycle pulse on the cycle a grant is revoked by MAX_HOLD expiry.
- idle  output  1  high while in IDLE state.

Behaviour:
- Reset (async assert, sync release by clk): state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, idle=1, hold_cnt=0, mask=0.
- Encode function: pick the highest set bit of the candidate vector. 4'b0000 gives no winner.
- States: IDLE, GRANT, RELEASE. All outputs are registered from state, owner, hold_cnt and mask.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise go to GRANT with owner=encode(req) and hold_cnt=0.
  - Latency: req sampled at edge n, gnt visible after edge n+1.
- GRANT:
  - gnt=1<<owner, gnt_id=owner, gnt_valid=1. hold_cnt increments once per cycle.
  - req[owner]==0: go to RELEASE, mask=0, timeout=0.
  - Else if hold_cnt==MAX_HOLD-1: go to RELEASE, mask=1<<owner, timeout=1 for that RELEASE cycle.
  - Else stay in GRANT.
  - Other requesters, including higher-priority ones, never preempt an active grant; only release or timeout ends it.
  - A grant therefore lasts at most MAX_HOLD cycles.
- RELEASE (exactly one cycle, gnt=0):
  - cand = req & ~mask.
  - cand != 0: go to GRANT with owner=encode(cand).
  - Else if req != 0 (only the masked requester remains): go to GRANT with owner=encode(req).
  - Else: go to IDLE.
  - mask is cleared when leaving RELEASE.
- Back-to-back owners are always separated by exactly one gnt=0 cycle.
- Simultaneous events:
  - Owner drops req on the same cycle hold_cnt reaches MAX_HOLD-1: treat as a normal release (timeout=0, no mask).
  - Requests changing during RELEASE are sampled at the RELEASE edge.
- gnt is never multi-hot. gnt_id is held at its last value when gnt_valid=0.
- Mid-operation reset: outputs drop to reset values immediately, asynchronously. After reset, arbitration resumes from IDLE.
- hold_cnt cannot wrap: MAX_HOLD <= 2**CNT_W is required.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> idle=1, gnt=0, gnt_valid=0 throughout.
- req=4'b0101 at edge n -> after edge n+1 gnt=4'b0100, gnt_id=2. Hold req for 3 cycles, then req=4'b0001 -> one gnt=0 cycle, then gnt=4'b0001, gnt_id=0.
- req=4'b1111 held constant, MAX_HOLD=8:
  - gnt=4'b1000 for 8 cycles, then timeout=1 with gnt=0.
  - Then gnt=4'b0100 for 8 cycles.
  - Then gnt=4'b1000 again.
- req=4'b0001 granted, then req[3] rises -> gnt stays 4'b0001 until req[0] drops or timeout; then gnt=4'b1000 after one dead cycle.
- Only req[1] held for 20 cycles -> grant 8 cycles, timeout pulse, regrant to requester 1 (only candidate); timeout pulses every 9 cycles.
- Assert rst_n=0 mid-grant (gnt=4'b0010) -> gnt=0, idle=1 without waiting for clk. Release reset with req=4'b0010 -> regranted 2 edges later.

Source files
------------

// File: rtl/req_arbiter_4.sv
// Four-requester fixed-priority arbiter: registered one-hot grant, hold while requested,
// forced release after MAX_HOLD cycles, one dead cycle between owners.
module req_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout,
  output logic       idle
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t             r_state, w_state_next;
  logic [1:0]         r_owner, w_owner_next;
  logic [CNT_W-1:0]   r_hold_cnt, w_hold_next;
  logic [3:0]         r_mask, w_mask_next;
  logic [3:0]         w_cand;

  logic [3:0]         r_gnt;
  logic [1:0]         r_gnt_id;
  logic               r_gnt_valid;
  logic               r_timeout;
  logic               r_idle;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  function automatic logic [1:0] encode(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_owner    <= 2'd0;
      r_hold_cnt <= '0;
      r_mask     <= 4'b0000;
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_hold_cnt <= w_hold_next;
      r_mask     <= w_mask_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_hold_next  = r_hold_cnt;
    w_mask_next  = r_mask;
    w_cand       = req & ~r_mask;
    case (r_state)
      S_IDLE: begin
        if (req != 4'b0000) begin
          w_state_next = S_GRANT;
          w_owner_next = encode(req);
          w_hold_next  = '0;
        end
      end
      S_GRANT: begin
        w_hold_next = r_hold_cnt + 1'b1;
        // A dropped request wins over expiry, so a simultaneous drop is a plain release.
        if (!req[r_owner]) begin
          w_state_next = S_RELEASE;
          w_mask_next  = 4'b0000;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_next = S_RELEASE;
          w_mask_next  = 4'b0001 << r_owner;
        end
      end
      S_RELEASE: begin
        w_mask_next = 4'b0000;
        w_hold_next = '0;
        if (w_cand != 4'b0000) begin
          w_state_next = S_GRANT;
          w_owner_next = encode(w_cand);
        end else if (req != 4'b0000) begin
          w_state_next = S_GRANT;
          w_owner_next = encode(req);
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output stage: one register behind the control state; a non-zero mask in
  // RELEASE can only come from an expiry, so it doubles as the timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt       <= 4'b0000;
      r_gnt_id    <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_idle      <= 1'b1;
    end else begin
      r_gnt       <= (r_state == S_GRANT) ? (4'b0001 << r_owner) : 4'b0000;
      r_gnt_id    <= (r_state == S_GRANT) ? r_owner : r_gnt_id;
      r_gnt_valid <= (r_state == S_GRANT);
      r_timeout   <= (r_state == S_RELEASE) && (r_mask != 4'b0000);
      r_idle      <= (r_state == S_IDLE);
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;
  assign idle      = r_idle;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Directed bench for req_arbiter_4: a behavioural model pushes expected outputs per
// clock edge into a scoreboard queue, popped and asserted on the following falling edge.
module tb_req_arbiter_4;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic       idle;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       to;
    logic       idle;
  } exp_t;

  exp_t sb_q[$];

  // Behavioural reference in terms of ownership, independent of output pipelining.
  typedef enum int {M_IDLE, M_GRANT, M_REL} mstate_t;
  mstate_t    m_state;
  int         m_owner;
  int         m_held;
  logic [3:0] m_excluded;
  logic       m_expired;
  exp_t       m_out;

  req_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int top_bit(input logic [3:0] v);
    for (int k = 3; k >= 0; k--) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_state    = M_IDLE;
    m_owner    = 0;
    m_held     = 0;
    m_excluded = 4'b0000;
    m_expired  = 1'b0;
    m_out      = '{gnt: 4'b0000, id: 2'd0, valid: 1'b0, to: 1'b0, idle: 1'b1};
    sb_q.delete();
  endtask

  // One clock edge of the reference: outputs reflect the state held before the edge.
  task automatic model_edge(input logic [3:0] r);
    logic [3:0] c;
    m_out.gnt   = (m_state == M_GRANT) ? 4'(1 << m_owner) : 4'b0000;
    m_out.id    = (m_state == M_GRANT) ? 2'(m_owner) : m_out.id;
    m_out.valid = (m_state == M_GRANT);
    m_out.to    = (m_state == M_REL) && m_expired;
    m_out.idle  = (m_state == M_IDLE);
    sb_q.push_back(m_out);
    case (m_state)
      M_IDLE: if (r != 0) begin
        m_state = M_GRANT; m_owner = top_bit(r); m_held = 1;
      end
      M_GRANT: begin
        if (!r[m_owner]) begin
          m_state = M_REL; m_expired = 1'b0; m_excluded = 4'b0000;
        end else if (m_held == MAX_HOLD) begin
          m_state = M_REL; m_expired = 1'b1; m_excluded = 4'(1 << m_owner);
        end else begin
          m_held++;
        end
      end
      default: begin
        c = r & ~m_excluded;
        m_expired  = 1'b0;
        m_excluded = 4'b0000;
        m_held     = 1;
        if (c != 0)      begin m_state = M_GRANT; m_owner = top_bit(c); end
        else if (r != 0) begin m_state = M_GRANT; m_owner = top_bit(r); end
        else             m_state = M_IDLE;
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    n_checks++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard: observed empty queue, expected one entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      assert (gnt === e.gnt) else begin
        n_fail++; $error("FAIL %s gnt: observed %b expected %b", tag, gnt, e.gnt);
      end
      n_checks++;
      assert (gnt_id === e.id) else begin
        n_fail++; $error("FAIL %s gnt_id: observed %0d expected %0d", tag, gnt_id, e.id);
      end
      n_checks++;
      assert (gnt_valid === e.valid) else begin
        n_fail++; $error("FAIL %s gnt_valid: observed %b expected %b", tag, gnt_valid, e.valid);
      end
      n_checks++;
      assert (timeout === e.to) else begin
        n_fail++; $error("FAIL %s timeout: observed %b expected %b", tag, timeout, e.to);
      end
      n_checks++;
      assert (idle === e.idle) else begin
        n_fail++; $error("FAIL %s idle: observed %b expected %b", tag, idle, e.idle);
      end
    end
    n_checks++;
    assert ($countones(gnt) <= 1) else begin
      n_fail++; $error("FAIL %s onehot: observed gnt %b expected at most one bit", tag, gnt);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] r, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      req = r;
      @(posedge clk);
      model_edge(r);
      @(negedge clk);
      check_outputs(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    assert (gnt === 4'b0000 && gnt_valid === 1'b0 && idle === 1'b1 && timeout === 1'b0 && gnt_id === 2'd0)
      else begin
        n_fail++;
        $error("FAIL reset: observed gnt=%b id=%0d v=%b to=%b idle=%b expected 0000/0/0/0/1",
               gnt, gnt_id, gnt_valid, timeout, idle);
      end
    rst_n = 1'b1;

    step("idle", 4'b0000, 5);
    step("prio_0101", 4'b0101, 4);
    n_checks++;
    assert (gnt === 4'b0100 && gnt_id === 2'd2) else begin
      n_fail++; $error("FAIL prio_direct: observed gnt=%b id=%0d expected 0100/2", gnt, gnt_id);
    end
    step("handover_0001", 4'b0001, 4);
    step("drain1", 4'b0000, 3);

    step("all_req", 4'b1111, 30);
    step("drain2", 4'b0000, 3);

    step("low_owner", 4'b0001, 3);
    step("no_preempt", 4'b1001, 4);
    n_checks++;
    assert (gnt === 4'b0001) else begin
      n_fail++; $error("FAIL no_preempt_direct: observed gnt=%b expected 0001", gnt);
    end
    step("high_after", 4'b1000, 4);
    step("drain3", 4'b0000, 3);

    step("single_req1", 4'b0010, 20);
    step("drain4", 4'b0000, 3);

    step("pre_reset", 4'b0010, 4);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    assert (gnt === 4'b0000 && idle === 1'b1 && gnt_valid === 1'b0) else begin
      n_fail++; $error("FAIL async_reset: observed gnt=%b idle=%b v=%b expected 0000/1/0",
                       gnt, idle, gnt_valid);
    end
    model_reset();
    req = 4'b0010;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", 4'b0010, 2);
    n_checks++;
    assert (gnt === 4'b0010 && gnt_id === 2'd1) else begin
      n_fail++; $error("FAIL regrant_direct: observed gnt=%b id=%0d expected 0010/1", gnt, gnt_id);
    end
    step("drain5", 4'b0000, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
